// File: rtl/camera_pkg.sv
// Shared types and default geometry for the camera capture path.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } cap_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

endpackage

// File: rtl/camera_capture_sync_edge.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign rise = sync & ~sync_q;

endmodule

// File: rtl/camera_capture.sv
// Single-frame RGB565 capture into a linear frame-buffer write stream.
// Optional 2x2 decimation is enabled by defining CAPTURE_DECIMATE_EN.
module camera_capture
  import camera_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fpga_href,
  input  logic              fpga_vsync,
  input  logic [7:0]        fpga_data,
  input  logic              fpga_shutter,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  // Counters saturate one past the active size so long lines/frames cannot wrap.
  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 2);
`ifdef CAPTURE_DECIMATE_EN
  localparam int ROW_STRIDE = H_ACTIVE / 2;
`else
  localparam int ROW_STRIDE = H_ACTIVE;
`endif

  cap_state_t        state_q;
  cap_state_t        state_d;
  logic              href_r;
  logic              href_q;
  logic              vsync_r;
  logic              vsync_q;
  logic [7:0]        data_r;
  logic [7:0]        hi_q;
  logic              phase_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [YW-1:0]     y_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              shutter_rise;
  logic              href_fall;
  logic              vsync_fall;
  logic              vsync_rise;
  logic              capturing;
  logic              arming;
  logic              in_range;
  logic              keep;
  logic              row_step;
  logic              line_end;
  logic              line_bad;
  rgb565_t           pixel;

  sync_edge u_shutter (
    .clk      (clk),
    .reset    (reset),
    .async_in (fpga_shutter),
    .rise     (shutter_rise)
  );

  assign href_fall  = href_q & ~href_r;
  assign vsync_fall = vsync_q & ~vsync_r;
  assign vsync_rise = vsync_r & ~vsync_q;
  assign capturing  = (state_q == CAPTURE);
  assign arming     = (state_q == IDLE) && shutter_rise;
  assign line_end   = capturing && href_fall;
  assign line_bad   = (x_q != XW'(H_ACTIVE)) || phase_q;
  assign in_range   = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
  assign pixel      = rgb565_t'({hi_q, data_r});
`ifdef CAPTURE_DECIMATE_EN
  assign keep       = in_range && !x_q[0] && !y_q[0];
  assign row_step   = !y_q[0];
`else
  assign keep       = in_range;
  assign row_step   = 1'b1;
`endif

  // A line ending on the same cycle as vsync rises must count toward the frame check.
  assign y_next = (line_end && (y_q <= YW'(V_ACTIVE))) ? y_q + YW'(1) : y_q;

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    case (state_q)
      IDLE:    if (shutter_rise) state_d = ARM;
      ARM:     if (vsync_fall) state_d = CAPTURE;
      CAPTURE: if (vsync_rise) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      href_r     <= 1'b0;
      href_q     <= 1'b0;
      vsync_r    <= 1'b0;
      vsync_q    <= 1'b0;
      data_r     <= '0;
      hi_q       <= '0;
      phase_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      frame_err  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      href_r  <= fpga_href;
      vsync_r <= fpga_vsync;
      data_r  <= fpga_data;
      href_q  <= href_r;
      vsync_q <= vsync_r;
      state_q <= state_d;
      wr_en   <= 1'b0;

      if (arming) begin
        phase_q    <= 1'b0;
        x_q        <= '0;
        y_q        <= '0;
        addr_q     <= '0;
        row_base_q <= '0;
        frame_err  <= 1'b0;
      end else if (capturing) begin
        if (href_r) begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            hi_q <= data_r;
          end else begin
            if (x_q <= XW'(H_ACTIVE)) x_q <= x_q + XW'(1);
            if (keep) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_q;
              wr_data <= pixel;
              addr_q  <= addr_q + ADDR_W'(1);
            end else if (!in_range) begin
              frame_err <= 1'b1;
            end
          end
        end else if (href_fall) begin
          // Re-base at each line so a short line cannot shift the next one.
          x_q     <= '0;
          phase_q <= 1'b0;
          y_q     <= y_next;
          if (row_step) begin
            row_base_q <= row_base_q + ADDR_W'(ROW_STRIDE);
            addr_q     <= row_base_q + ADDR_W'(ROW_STRIDE);
          end else begin
            addr_q <= row_base_q;
          end
          if (line_bad) frame_err <= 1'b1;
        end
        if (vsync_rise && (y_next != YW'(V_ACTIVE))) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Self-checking bench for camera_capture using a small 4-wide frame and a
// frame-level reference model of the expected write stream.
module tb_camera_capture;

  localparam int H  = 4;
`ifdef CAPTURE_DECIMATE_EN
  localparam int V   = 4;
  localparam bit DEC = 1'b1;
`else
  localparam int V   = 2;
  localparam bit DEC = 1'b0;
`endif
  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          fpga_href;
  logic          fpga_vsync;
  logic [7:0]    fpga_data;
  logic          fpga_shutter;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit done_prev = 1'b0;

  int          got_addr[$];
  logic [15:0] got_data[$];
  int          exp_addr[$];
  logic [15:0] exp_data[$];
  int          frame_lens[$];
  logic [7:0]  frame_bytes[$];

  camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fpga_href    (fpga_href),
    .fpga_vsync   (fpga_vsync),
    .fpga_data    (fpga_data),
    .fpga_shutter (fpga_shutter),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Record every write and check that frame_done never lasts two cycles.
  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(wr_data);
    end
    if (frame_done) begin
      checks++;
      if (done_prev) begin
        errors++;
        $display("[TB] FAIL done_pulse: frame_done high 2 cycles, required 1");
      end
      done_cnt++;
    end
    done_prev = frame_done;
  end

  function automatic void build_model();
    int pos = 0;
    exp_addr.delete();
    exp_data.delete();
    for (int y = 0; y < frame_lens.size(); y++) begin
      for (int p = 0; p < frame_lens[y] / 2; p++) begin
        if (p < H && y < V && (!DEC || (p % 2 == 0 && y % 2 == 0))) begin
          exp_addr.push_back(DEC ? (y / 2) * (H / 2) + p / 2 : y * H + p);
          exp_data.push_back({frame_bytes[pos + 2 * p], frame_bytes[pos + 2 * p + 1]});
        end
      end
      pos += frame_lens[y];
    end
  endfunction

  function automatic bit model_err();
    bit e = (frame_lens.size() != V);
    foreach (frame_lens[i]) if (frame_lens[i] != 2 * H) e = 1'b1;
    return e;
  endfunction

  task automatic make_frame(input int nlines, input int odd_line, input bit seq);
    int cnt = 0;
    frame_lens.delete();
    frame_bytes.delete();
    for (int y = 0; y < nlines; y++) begin
      int n = (y == odd_line) ? 2 * H - 1 : 2 * H;
      frame_lens.push_back(n);
      for (int i = 0; i < n; i++) begin
        frame_bytes.push_back(seq ? 8'(cnt) : 8'($urandom));
        cnt++;
      end
    end
    build_model();
  endtask

  task automatic press_shutter();
    fpga_shutter = 1'b1;
    repeat (4) @(negedge clk);
    fpga_shutter = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drive_frame(input bit tight, input int reset_at, output int writes_at_reset);
    int pos = 0;
    writes_at_reset = -1;
    got_addr.delete();
    got_data.delete();
    fpga_vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int y = 0; y < frame_lens.size(); y++) begin
      for (int i = 0; i < frame_lens[y]; i++) begin
        fpga_href = 1'b1;
        fpga_data = frame_bytes[pos];
        pos++;
        @(negedge clk);
        if (pos == reset_at) begin
          reset = 1'b1;
          @(negedge clk);
          checks++;
          if ({wr_en, busy, frame_done, frame_err} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_line: en/busy/done/err=%b%b%b%b addr=%0d data=%h, required all 0",
                     wr_en, busy, frame_done, frame_err, wr_addr, wr_data);
          end
          reset = 1'b0;
          writes_at_reset = got_addr.size();
        end
      end
      if (!(tight && y == frame_lens.size() - 1)) begin
        fpga_href = 1'b0;
        fpga_data = 8'($urandom);
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    fpga_href  = 1'b0;
    fpga_vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, busy, frame_done, frame_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: en/busy/done/err=%b%b%b%b, required 0000", wr_en, busy, frame_done, frame_err);
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus: addr=%0d data=%h, required 0/0000", wr_addr, wr_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int d0;
    int dummy;
    press_shutter();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_armed_busy: busy=%b, required 1", busy);
    end
    make_frame(V, -1, 1'b1);
    d0 = done_cnt;
    drive_frame(1'b0, -1, dummy);
    checks++;
    if (got_addr.size() !== exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL basic_count: writes=%0d, required %0d", got_addr.size(), exp_addr.size());
    end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL basic_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_status: done=%0d err=%b busy=%b, required 1/0/0", done_cnt - d0, frame_err, busy);
    end
  endtask

  task automatic test_no_shutter();
    int d0 = done_cnt;
    int total = 0;
    int dummy;
    for (int f = 0; f < 2; f++) begin
      make_frame(V, -1, 1'b0);
      drive_frame(1'b0, -1, dummy);
      total += got_addr.size();
    end
    checks++;
    if (total !== 0 || done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_shutter: writes=%0d done=%0d busy=%b, required 0/0/0", total, done_cnt - d0, busy);
    end
  endtask

  task automatic test_odd_line();
    int d0;
    int dummy;
    press_shutter();
    make_frame(V, 0, 1'b0);
    d0 = done_cnt;
    drive_frame(1'b0, -1, dummy);
    checks++;
    if (got_addr.size() !== exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL odd_count: writes=%0d, required %0d", got_addr.size(), exp_addr.size());
    end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL odd_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (frame_err !== model_err() || done_cnt - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL odd_status: err=%b done=%0d, required %b/1", frame_err, done_cnt - d0, model_err());
    end
  endtask

  task automatic test_extra_line();
    int d0;
    int dummy;
    press_shutter();
    make_frame(V + 1, -1, 1'b0);
    d0 = done_cnt;
    drive_frame(1'b0, -1, dummy);
    checks++;
    if (got_addr.size() !== exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL extra_count: writes=%0d, required %0d", got_addr.size(), exp_addr.size());
    end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL extra_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (frame_err !== 1'b1 || done_cnt - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL extra_status: err=%b done=%0d, required 1/1", frame_err, done_cnt - d0);
    end
  endtask

  task automatic test_tight_end();
    int d0;
    int dummy;
    press_shutter();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arm_clears_err: err=%b, required 0", frame_err);
    end
    make_frame(V, -1, 1'b0);
    d0 = done_cnt;
    drive_frame(1'b1, -1, dummy);
    checks++;
    if (got_addr.size() !== exp_addr.size() || frame_err !== 1'b0 || done_cnt - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL tight_end: writes=%0d err=%b done=%0d, required %0d/0/1",
               got_addr.size(), frame_err, done_cnt - d0, exp_addr.size());
    end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL tight_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_shutter_ignored();
    int first;
    int dummy;
    press_shutter();
    press_shutter();
    make_frame(V, -1, 1'b0);
    drive_frame(1'b0, -1, dummy);
    first = got_addr.size();
    make_frame(V, -1, 1'b0);
    drive_frame(1'b0, -1, dummy);
    checks++;
    if (first !== H * V / (DEC ? 4 : 1) || got_addr.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL shutter_ignored: first=%0d second=%0d busy=%b, required %0d/0/0",
               first, got_addr.size(), busy, H * V / (DEC ? 4 : 1));
    end
  endtask

  task automatic test_reset_mid_capture();
    int d0;
    int at_reset;
    int dummy;
    press_shutter();
    make_frame(V, -1, 1'b0);
    d0 = done_cnt;
    drive_frame(1'b0, 5, at_reset);
    checks++;
    if (at_reset < 0 || got_addr.size() !== at_reset || done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_writes: writes_after=%0d done=%0d busy=%b, required 0/0/0",
               got_addr.size() - at_reset, done_cnt - d0, busy);
    end
    press_shutter();
    make_frame(V, -1, 1'b0);
    drive_frame(1'b0, -1, dummy);
    checks++;
    if (got_addr.size() !== exp_addr.size() || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_recapture: writes=%0d err=%b, required %0d/0", got_addr.size(), frame_err, exp_addr.size());
    end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL recapture_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    fpga_href    = 1'b0;
    fpga_vsync   = 1'b1;
    fpga_data    = 8'h00;
    fpga_shutter = 1'b0;
    $display("[TB] camera_capture bench, %0dx%0d decimate=%0d", H, V, DEC);
    test_reset();
    test_basic_frame();
    test_no_shutter();
    test_odd_line();
    test_extra_line();
    test_tight_end();
    test_shutter_ignored();
    test_reset_mid_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
